// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide, combinationally read data memory.
// Optional MISALIGN_TRAP_EN: reject misaligned H/W accesses instead of aligning them down.
module load_store_unit #(
  parameter int unsigned WORD_ADDR_BITS = 5
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_req,
  output logic        O_ready,
  input  logic        I_we,
  input  logic [2:0]  I_funct3,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  output logic [31:0] O_rdata,
  output logic        O_done,
  output logic        O_misaligned,
  output logic        O_mem_memrw,
  output logic [31:0] O_mem_address,
  output logic [31:0] O_mem_data,
  input  logic [31:0] I_mem_data
);

  localparam int unsigned IDX_MSB = WORD_ADDR_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;
  logic        memrw_q, memrw_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] req_addr_c;
  logic        legal_c;
  logic        misalign_c;
  logic        unused_addr_c;

  // Select, shift down and extend the addressed lane of a read word.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{lane[7]}}, lane[7:0]};
      3'b001:  return {{16{lane[15]}}, lane[15:0]};
      3'b100:  return {24'h000000, lane[7:0]};
      3'b101:  return {16'h0000, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  // Replace one byte/half lane of the read word with store data.
  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wdata,
                                        input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] mask;
    mask = f3[0] ? 32'h0000FFFF : 32'h000000FF;
    return (word & ~(mask << {off, 3'b000})) | ((wdata & mask) << {off, 3'b000});
  endfunction

  always_comb begin
    case (I_funct3[1:0])
      2'b01:   req_addr_c = {I_addr[31:1], 1'b0};
      2'b10:   req_addr_c = {I_addr[31:2], 2'b00};
      default: req_addr_c = I_addr;
    endcase
  end

  assign legal_c = I_we ? (I_funct3 == 3'b000 || I_funct3 == 3'b001 || I_funct3 == 3'b010)
                        : (I_funct3 != 3'b011 && I_funct3[2:1] != 2'b11);

`ifdef MISALIGN_TRAP_EN
  assign misalign_c = (I_funct3[1:0] == 2'b01 && I_addr[0]) ||
                      (I_funct3[1:0] == 2'b10 && I_addr[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  assign unused_addr_c = ^{I_addr[31:IDX_MSB+1], req_addr_c[31:IDX_MSB+1]};

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      mis_q      <= 1'b0;
      memrw_q    <= 1'b0;
      rdata_q    <= 32'h0;
      mem_addr_q <= 32'h0;
      mem_data_q <= 32'h0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      memrw_q    <= memrw_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next state and registered outputs; write strobe only ever raised on entry to WR.
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    memrw_d    = 1'b0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    we_d       = we_q;
    f3_d       = f3_q;
    off_d      = off_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (I_req) begin
          we_d    = I_we;
          f3_d    = I_funct3;
          off_d   = req_addr_c[1:0];
          wdata_d = I_wdata;
          if (!legal_c) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            rdata_d = 32'h0;
          end else if (misalign_c) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            mem_addr_d = 32'(req_addr_c[IDX_MSB:2]);
            if (I_we && I_funct3[1:0] == 2'b10) begin
              state_d    = S_WR;
              memrw_d    = 1'b1;
              mem_data_d = I_wdata;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (we_q) begin
          state_d    = S_WR;
          memrw_d    = 1'b1;
          mem_data_d = merge(I_mem_data, wdata_q, f3_q, off_q);
        end else begin
          state_d = S_RESP;
          done_d  = 1'b1;
          rdata_d = extract(I_mem_data, f3_q, off_q);
        end
      end
      S_WR: begin
        state_d = S_RESP;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  assign O_ready       = ready_q;
  assign O_done        = done_q;
  assign O_misaligned  = mis_q;
  assign O_mem_memrw   = memrw_q;
  assign O_rdata       = rdata_q;
  assign O_mem_address = mem_addr_q;
  assign O_mem_data    = mem_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random ops against a byte-level model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        done;
  logic        mis;
  logic        memrw;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:31];
  logic [31:0] ref_mem [0:31];
  logic        init_en;
  int          wr_cnt;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.WORD_ADDR_BITS(5)) dut (
    .I_clk(clk), .I_rst(rst), .I_req(req), .O_ready(ready), .I_we(we),
    .I_funct3(f3), .I_addr(addr), .I_wdata(wdata), .O_rdata(rdata), .O_done(done),
    .O_misaligned(mis), .O_mem_memrw(memrw), .O_mem_address(mem_address),
    .O_mem_data(mem_wdata), .I_mem_data(mem_rdata)
  );

  // Behavioural data_memory: combinational read, write on the clock edge when memrw is set.
  assign mem_rdata = mem[mem_address[4:0]];
  always @(posedge clk) begin
    if (init_en) begin
      mem    <= ref_mem;
      wr_cnt <= 0;
    end else if (memrw) begin
      mem[mem_address[4:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction: model computes expectations from byte-addressing rules, then DUT is driven.
  task automatic run_op(input bit st, input bit [2:0] fc, input bit [31:0] a,
                        input bit [31:0] wd, input bit hold);
    int unsigned size, ea, idx, off, exp_lat, exp_wr, w0, cyc, guard;
    bit legal, trap, busy_ok;
    bit [31:0] v, w;
    bit [7:0] b;
    legal = st ? (fc <= 3'd2) : (fc inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = (fc[1:0] == 2'd0) ? 1 : (fc[1:0] == 2'd1) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
    trap = legal && (a % size != 0);
`else
    trap = 1'b0;
`endif
    ea  = a - (a % size);
    idx = (ea / 4) % 32;
    off = ea % 4;
    exp_wr = 0;
    if (!legal) begin
      exp_lat = 1; exp_rdata = 32'h0;
    end else if (trap) begin
      exp_lat = 1;
    end else if (!st) begin
      exp_lat = 2;
      v = ref_mem[idx] >> (8 * off);
      if (size == 1) begin
        v = v % 256;
        if (!fc[2] && v >= 128) v = v + 32'hFFFFFF00;
      end else if (size == 2) begin
        v = v % 65536;
        if (!fc[2] && v >= 32768) v = v + 32'hFFFF0000;
      end
      exp_rdata = v;
    end else begin
      exp_lat = (size == 4) ? 2 : 3;
      exp_wr  = 1;
      w = ref_mem[idx];
      for (int k = 0; k < int'(size); k++) begin
        b = wd[8*k +: 8];
        w[8*(off+k) +: 8] = b;
      end
      ref_mem[idx] = w;
    end

    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin @(negedge clk); guard++; end
    check("ready_idle", 32'(ready), 32'd1);
    w0 = wr_cnt;
    req = 1'b1; we = st; f3 = fc; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    if (!hold) req = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 8) begin
      if (ready) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    check("done", 32'(done), 32'd1);
    check("latency", cyc, exp_lat);
    check("ready_busy", 32'(busy_ok && !ready), 32'd1);
    check("misaligned", 32'(mis), 32'(trap));
    check("rdata", rdata, exp_rdata);
    check("writes", wr_cnt - w0, exp_wr);
    check("mem_word", mem[idx], ref_mem[idx]);
    check("addr_hi", mem_address & 32'hFFFFFFE0, 32'h0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int w0;
    rst = 1'b1; req = 1'b0; we = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    init_en = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    exp_rdata = 32'h0;
    repeat (3) @(negedge clk);
    init_en = 1'b0;
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_outs", {29'h0, done, memrw, mis}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_maddr", mem_address, 32'h0);
    check("rst_mdata", mem_wdata, 32'h0);

    // Reset during an SB read phase: abandoned, memory untouched.
    @(negedge clk);
    w0 = wr_cnt;
    req = 1'b1; we = 1'b1; f3 = 3'b000; addr = 32'h09; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_outs", {28'h0, ready, done, memrw, mis}, 32'h8);
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_maddr", mem_address, 32'h0);
    check("midrst_mdata", mem_wdata, 32'h0);
    check("midrst_writes", wr_cnt - w0, 0);
    check("midrst_mem", mem[2], ref_mem[2]);
    rst = 1'b0;

    run_op(1, 3'b010, 32'h08, 32'hDEADBEEF, 0);
    run_op(0, 3'b010, 32'h08, 32'h0, 0);
    check("lw_deadbeef", rdata, 32'hDEADBEEF);
    run_op(1, 3'b000, 32'h09, 32'h5A, 0);
    check("sb_mem2", mem[2], 32'hDEAD5AEF);
    run_op(0, 3'b000, 32'h09, 32'h0, 0);
    check("lb_09", rdata, 32'h0000005A);
    run_op(0, 3'b000, 32'h0B, 32'h0, 0);
    check("lb_0b", rdata, 32'hFFFFFFDE);
    run_op(0, 3'b100, 32'h0B, 32'h0, 0);
    check("lbu_0b", rdata, 32'h000000DE);
    run_op(1, 3'b010, 32'h0C, 32'h0, 0);
    run_op(1, 3'b001, 32'h0E, 32'h8001, 0);
    check("sh_mem3", mem[3], 32'h80010000);
    run_op(0, 3'b001, 32'h0E, 32'h0, 0);
    check("lh_0e", rdata, 32'hFFFF8001);
    run_op(0, 3'b101, 32'h0E, 32'h0, 0);
    check("lhu_0e", rdata, 32'h00008001);
    run_op(1, 3'b010, 32'h80, 32'h11, 1);
    check("wrap_mem0", mem[0], 32'h11);
    run_op(1, 3'b000, 32'h13, 32'hA5, 1);
    run_op(0, 3'b010, 32'h05, 32'h0, 0);
    run_op(0, 3'b011, 32'h10, 32'h0, 0);
    run_op(1, 3'b110, 32'h10, 32'hFFFFFFFF, 0);

    for (int n = 0; n < 300; n++) begin
      bit s;
      bit [2:0] c;
      s = 1'($urandom_range(0, 1));
      if (s) c = ($urandom_range(0, 9) == 0) ? 3'b111 : 3'($urandom_range(0, 2));
      else   c = 3'($urandom_range(0, 7));
      run_op(s, c, $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
